// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to unsigned binary converter.
// Digits are folded MSD-first, one per clock, as acc = acc*10 + digit.
// A word with any digit above 9 skips the fold and reports err with a zero result.
module bcd_to_binary_seq #(
    parameter int NDIGITS = 4,
    parameter int BIN_W   = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NDIGITS-1:0]   bcd_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BIN_W-1:0]       bin_out,
    output logic                   err
);

    localparam int IN_W  = 4 * NDIGITS;
    localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NDIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    shreg_q, shreg_d;
    logic [BIN_W-1:0]   acc_q, acc_d;
    logic [BIN_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               err_q, err_d;

    // True when any nibble of the word is outside 0..9.
    function automatic logic has_bad_digit(input logic [IN_W-1:0] w);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (w[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // acc*10 + digit using shifts; BIN_W is sized so this cannot overflow.
    function automatic logic [BIN_W-1:0] mul10_add(input logic [BIN_W-1:0] acc,
                                                   input logic [3:0]       digit);
        return (acc << 3) + (acc << 1) + BIN_W'(digit);
    endfunction

    // in_ready depends on state only, so there is no in_valid -> in_ready path.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign bin_out   = bin_q;
    assign err       = err_q;

    // Next-state and datapath update for the IDLE/CONV/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        bin_d       = bin_q;
        err_d       = err_q;
        acc_next    = mul10_add(acc_q, shreg_q[IN_W-1 -: 4]);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d = bcd_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    if (has_bad_digit(bcd_in)) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        bin_d       = '0;
                        err_d       = 1'b1;
                    end else begin
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                acc_d   = acc_next;
                shreg_d = shreg_q << 4;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_DIGIT) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    bin_d       = acc_next;
                    err_d       = 1'b0;
                end
            end
            DONE: begin
                // Result stays frozen until the consumer takes it.
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            bin_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            bin_q       <= bin_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: decimal reference model with a
// per-cycle compare process, plus directed vectors with literal expectations.
module tb_bcd_to_binary_seq;

    localparam int N  = 4;
    localparam int BW = 14;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   bcd_in;
    logic          out_valid;
    logic          out_ready;
    logic [13:0]   bin_out;
    logic          err;

    logic          in_valid2;
    logic          in_ready2;
    logic [7:0]    bcd2;
    logic          out_valid2;
    logic          out_ready2;
    logic [6:0]    bin2;
    logic          err2;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    bcd_to_binary_seq #(.NDIGITS(N), .BIN_W(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    bcd_to_binary_seq #(.NDIGITS(2), .BIN_W(7)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .bcd_in    (bcd2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .bin_out   (bin2),
        .err       (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    typedef struct {
        logic [13:0] bin;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [13:0] last_bin = '0;
    logic        prev_ov  = 1'b0;

    // Decimal value of a packed-BCD word: sum of digit * 10^position.
    function automatic exp_t model(input logic [15:0] w, input int now);
        exp_t r;
        int   val;
        int   pw;
        logic bad;
        logic [15:0] t;
        val = 0;
        pw  = 1;
        bad = 1'b0;
        t   = w;
        for (int i = 0; i < N; i++) begin
            if (t[3:0] > 4'd9) bad = 1'b1;
            val = val + int'(t[3:0]) * pw;
            pw  = pw * 10;
            t   = t >> 4;
        end
        r.err = bad;
        r.bin = bad ? 14'd0 : 14'(val);
        r.due = bad ? now + 1 : now + N + 1;
        return r;
    endfunction

    function automatic logic [15:0] enc(input int v);
        logic [15:0] w;
        int          x;
        x = v;
        w = '0;
        for (int i = 0; i < N; i++) begin
            w[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return w;
    endfunction

    // Compare process: checks every cycle, sampled on the falling edge.
    always @(negedge clk) begin
        logic exp_rdy;
        exp_t e;
        if (!rst_n) begin
            q.delete();
            last_bin = '0;
            prev_ov  = 1'b0;
            compared++;
            if (out_valid !== 1'b0 || bin_out !== 14'd0 || err !== 1'b0 || in_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL reset_state: ov=%b bin=%0d err=%b rdy=%b, want ov=0 bin=0 err=0 rdy=1",
                         out_valid, bin_out, err, in_ready);
            end
        end else begin
            exp_rdy = (q.size() == 0);
            compared++;
            if (in_ready !== exp_rdy) begin
                mismatched++;
                $display("FAIL in_ready @%0d: got %b want %b", cyc, in_ready, exp_rdy);
            end
            if (out_valid === 1'b1) begin
                compared++;
                if (q.size() == 0) begin
                    mismatched++;
                    $display("FAIL spurious_out_valid @%0d: got bin=%0d err=%b, want no result",
                             cyc, bin_out, err);
                end else begin
                    e = q[0];
                    if (bin_out !== e.bin || err !== e.err) begin
                        mismatched++;
                        $display("FAIL result @%0d: got bin=%0d err=%b want bin=%0d err=%b",
                                 cyc, bin_out, err, e.bin, e.err);
                    end
                    if (!prev_ov) begin
                        compared++;
                        if (cyc != e.due) begin
                            mismatched++;
                            $display("FAIL latency: out_valid rose at cycle %0d want %0d", cyc, e.due);
                        end
                    end
                    if (out_ready) begin
                        last_bin = e.bin;
                        void'(q.pop_front());
                    end
                end
            end else begin
                compared++;
                if (out_valid !== 1'b0 || bin_out !== last_bin) begin
                    mismatched++;
                    $display("FAIL idle_hold @%0d: got ov=%b bin=%0d want ov=0 bin=%0d",
                             cyc, out_valid, bin_out, last_bin);
                end
                if (q.size() != 0) begin
                    compared++;
                    if (cyc >= q[0].due) begin
                        mismatched++;
                        $display("FAIL late_result @%0d: out_valid=0 want 1 (due %0d)", cyc, q[0].due);
                    end
                end
            end
            if (in_valid && exp_rdy) q.push_back(model(bcd_in, cyc));
            prev_ov = out_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input logic [15:0] w);
        logic ok;
        in_valid = 1'b1;
        bcd_in   = w;
        ok       = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL accept_timeout: in_ready=0 for 100 cycles, want 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bcd_in   = 16'hFFFF;
    endtask

    task automatic wait_result(input logic [13:0] exp_bin, input logic exp_err, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i != 0 || 1'b1) @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL %s: out_valid=0 after 100 cycles, want 1", name);
        end else if (bin_out !== exp_bin || err !== exp_err) begin
            mismatched++;
            $display("FAIL %s: got bin=%0d err=%b want bin=%0d err=%b", name, bin_out, err, exp_bin, exp_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check2(input logic [7:0] w, input logic [6:0] exp_bin, input logic exp_err);
        logic ok;
        in_valid2 = 1'b1;
        bcd2      = w;
        ok        = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready2) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (out_valid2) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL n2_timeout %h: no result within bound, want bin=%0d", w, exp_bin);
        end else if (bin2 !== exp_bin || err2 !== exp_err) begin
            mismatched++;
            $display("FAIL n2_result %h: got bin=%0d err=%b want bin=%0d err=%b", w, bin2, err2, exp_bin, exp_err);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic ok;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        bcd_in     = '0;
        out_ready  = 1'b1;
        in_valid2  = 1'b0;
        bcd2       = '0;
        out_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(16'h0000);  wait_result(14'd0,    1'b0, "zero");
        send(16'h9999);  wait_result(14'h270F, 1'b0, "all_nines");
        send(16'h1234);  wait_result(14'd1234, 1'b0, "b2b_first");
        send(16'h0907);  wait_result(14'd907,  1'b0, "b2b_second");
        send(16'h12A4);  wait_result(14'd0,    1'b1, "bad_digit");
        send(16'h0042);  wait_result(14'd42,   1'b0, "after_err");

        // Backpressure: hold the result for 10 cycles with stray in_valid pulses.
        out_ready = 1'b0;
        send(16'h0321);
        wait_result(14'd321, 1'b0, "held_first");
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            bcd_in   = 16'h5555;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        compared++;
        if (out_valid !== 1'b1 || bin_out !== 14'd321) begin
            mismatched++;
            $display("FAIL held_after_10: got ov=%b bin=%0d want ov=1 bin=321", out_valid, bin_out);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bin_out !== 14'd321) begin
            mismatched++;
            $display("FAIL release: got rdy=%b ov=%b bin=%0d want rdy=1 ov=0 bin=321",
                     in_ready, out_valid, bin_out);
        end
        @(posedge clk);
        #1;

        // Reset pulse while converting, two digits into the fold.
        send(16'h1234);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b0 || bin_out !== 14'd0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_reset: got ov=%b bin=%0d rdy=%b want ov=0 bin=0 rdy=1",
                     out_valid, bin_out, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'h0005);  wait_result(14'd5, 1'b0, "after_reset");

        // Full sweep, streaming with in_valid held high.
        in_valid = 1'b1;
        bcd_in   = enc(0);
        for (int v = 0; v < 10000; v++) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                compared++;
                mismatched++;
                $display("FAIL sweep_accept %0d: in_ready=0 for 20 cycles, want 1", v);
                break;
            end
            @(posedge clk);
            #1;
            if (v == 9999) in_valid = 1'b0;
            else           bcd_in = enc(v + 1);
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL sweep_drain: %0d results outstanding, want 0", q.size());
        end

        // Two-digit build.
        check2(8'h99, 7'd99, 1'b0);
        check2(8'h42, 7'd42, 1'b0);
        check2(8'h9A, 7'd0,  1'b1);
        check2(8'h07, 7'd7,  1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
